// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the byte-serialising memory access unit.
// Used by the unit itself and by anything that talks to it.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int         BYTE_CNT  = 4;
    localparam logic [1:0] LAST_BYTE = 2'(BYTE_CNT - 1);

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Controller-side word bus plus byte-memory bus of the access unit.
// master = controller and byte memory, slave = mem_access_unit.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              mem_ready;
    logic              busy;
    logic              err;

    logic [ADDR_W-1:0] bmem_adr;
    logic [7:0]        bmem_wdata;
    logic [7:0]        bmem_rdata;
    logic              bmem_re;
    logic              bmem_we;

    modport master (
        output mem_read, mem_write, adr, write_data, bmem_rdata,
        input  read_data, mem_ready, busy, err,
        input  bmem_adr, bmem_wdata, bmem_re, bmem_we
    );

    modport slave (
        input  mem_read, mem_write, adr, write_data, bmem_rdata,
        output read_data, mem_ready, busy, err,
        output bmem_adr, bmem_wdata, bmem_re, bmem_we
    );

endinterface

// File: rtl/mem_access_unit_byte_lane_shifter.sv
// Big-endian byte lane select/insert: lane index k maps to bits [31-8k -: 8].
// Purely combinational, no state, no backpressure.
module byte_lane_shifter (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_sel_idx,
    output logic [7:0]  o_sel_byte,
    input  logic [31:0] i_acc,
    input  logic [1:0]  i_ins_idx,
    input  logic [7:0]  i_ins_byte,
    output logic [31:0] o_acc
);

    always_comb begin
        o_sel_byte = i_word[31:24];
        case (i_sel_idx)
            2'd0: o_sel_byte = i_word[31:24];
            2'd1: o_sel_byte = i_word[23:16];
            2'd2: o_sel_byte = i_word[15:8];
            2'd3: o_sel_byte = i_word[7:0];
            default: o_sel_byte = i_word[31:24];
        endcase
    end

    always_comb begin
        o_acc = i_acc;
        case (i_ins_idx)
            2'd0: o_acc[31:24] = i_ins_byte;
            2'd1: o_acc[23:16] = i_ins_byte;
            2'd2: o_acc[15:8]  = i_ins_byte;
            2'd3: o_acc[7:0]   = i_ins_byte;
            default: o_acc = i_acc;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Word access unit over a byte-wide memory: 4 byte cycles per legal access, big-endian.
// Latency: mem_ready 5 cycles after the sampling edge (1 cycle for rejected requests); requests outside IDLE are ignored.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_access_unit_if.slave      bus
);

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;
    logic [ADDR_W-1:0] r_bmem_adr;
    logic [7:0]        r_bmem_wdata;
    logic              r_bmem_re;
    logic              r_bmem_we;

    logic              w_req;
    logic              w_reject;
    logic              w_last;
    logic [1:0]        w_cnt_nxt;
    logic [31:0]       w_sel_word;
    logic [1:0]        w_sel_idx;
    logic [7:0]        w_sel_byte;
    logic [31:0]       w_rdata_nxt;

    assign w_req     = bus.mem_read | bus.mem_write;
    assign w_reject  = !is_aligned(bus.adr[1:0]) || (bus.mem_read && bus.mem_write);
    assign w_last    = (r_cnt == LAST_BYTE);
    assign w_cnt_nxt = r_cnt + 2'd1;

    // Byte strobes are registered, so the lane for the coming cycle is picked one edge early:
    // lane 0 straight from the request bus in IDLE, later lanes from the latched word.
    assign w_sel_word = (r_state == ST_IDLE) ? bus.write_data : r_wdata;
    assign w_sel_idx  = (r_state == ST_IDLE) ? 2'd0 : w_cnt_nxt;

    byte_lane_shifter u_lanes (
        .i_word     (w_sel_word),
        .i_sel_idx  (w_sel_idx),
        .o_sel_byte (w_sel_byte),
        .i_acc      (r_rdata),
        .i_ins_idx  (r_cnt),
        .i_ins_byte (bus.bmem_rdata),
        .o_acc      (w_rdata_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            r_adr        <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_bmem_adr   <= '0;
            r_bmem_wdata <= '0;
            r_bmem_re    <= 1'b0;
            r_bmem_we    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_adr   <= bus.adr;
                        r_wdata <= bus.write_data;
                        r_busy  <= 1'b1;
                        r_cnt   <= 2'd0;
                        if (w_reject) begin
                            r_state <= ST_DONE;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (bus.mem_read) begin
                            r_state    <= ST_READ;
                            r_bmem_adr <= bus.adr;
                            r_bmem_re  <= 1'b1;
                        end else begin
                            r_state      <= ST_WRITE;
                            r_bmem_adr   <= bus.adr;
                            r_bmem_we    <= 1'b1;
                            r_bmem_wdata <= w_sel_byte;
                        end
                    end
                end

                ST_READ, ST_WRITE: begin
                    if (r_state == ST_READ) begin
                        r_rdata <= w_rdata_nxt;
                    end
                    // Counter stays at 3 through DONE; it is re-armed on the next entry.
                    if (w_last) begin
                        r_state      <= ST_DONE;
                        r_ready      <= 1'b1;
                        r_bmem_re    <= 1'b0;
                        r_bmem_we    <= 1'b0;
                        r_bmem_adr   <= '0;
                        r_bmem_wdata <= '0;
                    end else begin
                        r_cnt      <= w_cnt_nxt;
                        r_bmem_adr <= r_adr + ADDR_W'(w_cnt_nxt);
                        if (r_state == ST_WRITE) begin
                            r_bmem_wdata <= w_sel_byte;
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.read_data  = r_rdata;
    assign bus.mem_ready  = r_ready;
    assign bus.busy       = r_busy;
    assign bus.err        = r_err;
    assign bus.bmem_adr   = r_bmem_adr;
    assign bus.bmem_wdata = r_bmem_wdata;
    assign bus.bmem_re    = r_bmem_re;
    assign bus.bmem_we    = r_bmem_we;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, hand-written corner sequences and random accesses
// checked against a byte-array reference model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(AW)) bus ();

    mem_access_unit #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            16: return 8'hAA;
            17: return 8'hBB;
            18: return 8'hCC;
            19: return 8'hDD;
            default: return 8'((i * 7 + 3) % 256);
        endcase
    endfunction

    // Byte memory seen by the DUT.
    logic [7:0] mem [0:255];
    logic       do_init;
    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
        end else if (bus.bmem_we) begin
            mem[bus.bmem_adr[7:0]] <= bus.bmem_wdata;
        end
    end
    assign bus.bmem_rdata = mem[bus.bmem_adr[7:0]];

    // Reference model: memory contents and the last legally read word.
    logic [7:0]  ref_mem [0:255];
    logic [31:0] ref_rd;
    logic        last_err;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drop_req();
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
    endtask

    // One access from the controller's side; requests held until mem_ready is seen.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input bit change, input bit hold);
        bit   legal;
        bit   done;
        int   lat;
        int   nre;
        int   nwe;
        logic [31:0] base;
        legal = (a[1:0] == 2'b00) && !(rd && wr);
        base  = {a[31:2], 2'b00};
        @(negedge clk);
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.adr        = a;
        bus.write_data = wd;
        done = 0; lat = 0; nre = 0; nwe = 0; last_err = 1'b0;
        for (int n = 1; n <= 12 && !done; n++) begin
            @(negedge clk);
            if (change && n == 2) begin
                bus.adr        = 32'h40;
                bus.write_data = ~wd;
            end
            check("busy_during", {31'd0, bus.busy}, 32'd1);
            if (bus.bmem_re) begin
                nre++;
                if (n <= BYTE_CNT) check("re_adr", bus.bmem_adr, a + 32'(n - 1));
                else               check("re_late", 32'(n), 32'(BYTE_CNT));
            end
            if (bus.bmem_we) begin
                nwe++;
                if (n <= BYTE_CNT) begin
                    check("we_adr", bus.bmem_adr, a + 32'(n - 1));
                    check("we_dat", {24'd0, bus.bmem_wdata}, {24'd0, wd[31 - 8 * (n - 1) -: 8]});
                end else begin
                    check("we_late", 32'(n), 32'(BYTE_CNT));
                end
            end
            if (bus.mem_ready) begin
                lat      = n;
                last_err = bus.err;
                done     = 1;
                if (!hold) drop_req();
            end
        end
        check("ready_seen", {31'd0, done}, 32'd1);
        if (!done) drop_req();

        if (legal && wr) begin
            for (int k = 0; k < BYTE_CNT; k++) ref_mem[8'(a) + 8'(k)] = wd[31 - 8 * k -: 8];
        end
        if (legal && rd) begin
            ref_rd = {ref_mem[8'(a)], ref_mem[8'(a) + 8'd1], ref_mem[8'(a) + 8'd2], ref_mem[8'(a) + 8'd3]};
        end

        check("latency", 32'(lat), legal ? 32'd5 : 32'd1);
        check("err", {31'd0, last_err}, legal ? 32'd0 : 32'd1);
        check("re_count", 32'(nre), (legal && rd) ? 32'(BYTE_CNT) : 32'd0);
        check("we_count", 32'(nwe), (legal && wr) ? 32'(BYTE_CNT) : 32'd0);
        check("read_data", bus.read_data, ref_rd);
        for (int k = 0; k < BYTE_CNT; k++)
            check("mem_byte", {24'd0, mem[8'(base) + 8'(k)]}, {24'd0, ref_mem[8'(base) + 8'(k)]});

        if (!hold) begin
            @(negedge clk);
            check("ready_pulse", {29'd0, bus.mem_ready, bus.busy, bus.err}, 32'd0);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {29'd0, bus.mem_ready, bus.busy, bus.err}, 32'd0);
        check({name, "_strobe"}, {30'd0, bus.bmem_re, bus.bmem_we}, 32'd0);
        check({name, "_badr"}, bus.bmem_adr, 32'd0);
        check({name, "_bwd"}, {24'd0, bus.bmem_wdata}, 32'd0);
        check({name, "_rdata"}, bus.read_data, 32'd0);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] adr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int seen;
        int kind;
        logic [31:0] a;

        tbl[0] = '{1, 0, 32'h10, 32'h0,        0, 32'hAABBCCDD};
        tbl[1] = '{0, 1, 32'h20, 32'h12345678, 0, 32'hAABBCCDD};
        tbl[2] = '{1, 0, 32'h22, 32'h0,        1, 32'hAABBCCDD};
        tbl[3] = '{1, 1, 32'h30, 32'h55555555, 1, 32'hAABBCCDD};
        tbl[4] = '{1, 0, 32'h20, 32'h0,        0, 32'h12345678};
        tbl[5] = '{0, 1, 32'h31, 32'h99999999, 1, 32'h12345678};
        tbl[6] = '{1, 0, 32'h00, 32'h0,        0, 32'h030A1118};
        tbl[7] = '{0, 1, 32'hFC, 32'hDEADBEEF, 0, 32'h030A1118};
        tbl[8] = '{1, 0, 32'hFC, 32'h0,        0, 32'hDEADBEEF};
        tbl[9] = '{1, 0, 32'h30, 32'h0,        0, 32'h535A6168};

        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        ref_rd = 32'd0;
        last_err = 1'b0;
        rst = 1'b1;
        do_init = 1'b1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.adr = 32'd0;
        bus.write_data = 32'd0;

        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        do_init = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("idle_after_reset");

        for (int i = 0; i < 10; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].adr, tbl[i].wdata, 0, 0);
            check("tbl_err", {31'd0, last_err}, {31'd0, tbl[i].exp_err});
            check("tbl_rdata", bus.read_data, tbl[i].exp_rdata);
        end

        // Address and data change mid-read must not disturb the access.
        access(1, 0, 32'h10, 32'h0, 1, 0);
        check("adr_change_rdata", bus.read_data, 32'hAABBCCDD);

        // Request held through DONE: not re-sampled there, but taken in the following IDLE.
        access(1, 0, 32'h10, 32'h0, 0, 1);
        @(negedge clk);
        check("hold_idle", {30'd0, bus.busy, bus.mem_ready}, 32'd0);
        @(negedge clk);
        check("hold_restart", {30'd0, bus.busy, bus.bmem_re}, 32'd3);
        check("hold_restart_adr", bus.bmem_adr, 32'h10);
        drop_req();
        seen = 0;
        for (int n = 0; n < 10 && seen == 0; n++) begin
            @(negedge clk);
            if (bus.mem_ready) seen = 1;
        end
        check("hold_drain", 32'(seen), 32'd1);
        check("hold_rdata", bus.read_data, 32'hAABBCCDD);
        @(negedge clk);

        // Reset in the 3rd WRITE cycle.
        @(negedge clk);
        bus.mem_write  = 1'b1;
        bus.adr        = 32'h20;
        bus.write_data = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        check("rst_pre_we", {31'd0, bus.bmem_we}, 32'd1);
        check("rst_pre_adr", bus.bmem_adr, 32'h22);
        #2 rst = 1'b1;
        #1 check_outputs_zero("rst_mid");
        bus.mem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.mem_ready || bus.bmem_we) seen++;
        end
        check("rst_no_ready", 32'(seen), 32'd0);
        check("rst_byte20", {24'd0, mem[8'h20]}, 32'hCA);
        check("rst_byte21", {24'd0, mem[8'h21]}, 32'hFE);
        check("rst_byte23", {24'd0, mem[8'h23]}, {24'd0, ref_mem[8'h23]});
        ref_mem[8'h20] = 8'hCA;
        ref_mem[8'h21] = 8'hFE;
        ref_mem[8'h22] = mem[8'h22];
        ref_rd = 32'd0;

        // Random mix against the reference model.
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            a    = 32'($urandom_range(0, 63)) * 32'd4;
            if (kind == 7 || kind == 8) a = a + 32'($urandom_range(1, 3));
            case (kind)
                0, 1, 2, 3: access(1, 0, a, 32'h0, 0, 0);
                4, 5, 6:    access(0, 1, a, $urandom, 0, 0);
                7:          access(1, 0, a, 32'h0, 0, 0);
                8:          access(0, 1, a, $urandom, 0, 0);
                default:    access(1, 1, a, $urandom, 0, 0);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_W, 32, width of word and byte addresses.
REQ-002 Port: clk  input  1  the single clock; every register updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: mem_read  input  1  level request from the multicycle controller for a word read.
REQ-005 Port: mem_write  input  1  level request from the multicycle controller for a word write.
REQ-006 Port: adr  input  ADDR_W  word address, already selected by IorD.
REQ-007 Port: write_data  input  32  word to store.
REQ-008 Port: read_data  output  32  assembled word, big-endian.
REQ-009 Port: mem_ready  output  1  one-cycle pulse when the access completes; the controller holds its state until this pulse.
REQ-010 Port: busy  output  1  high while an access is in progress.
REQ-011 Port: err  output  1  one-cycle pulse, coincident with mem_ready, for a rejected request.
REQ-012 Port: bmem_adr  output  ADDR_W  byte address to the byte-wide memory.
REQ-013 Port: bmem_wdata  output  8  byte to write.
REQ-014 Port: bmem_rdata  input  8  byte read; combinational from bmem_adr.
REQ-015 Port: bmem_re / bmem_we  output  1 each  byte read and byte write strobes.

Function
REQ-016 FSM states: IDLE, READ, WRITE, DONE.
REQ-017 IDLE: a request is sampled at a rising edge; adr and write_data are latched at that edge; busy goes high in the next cycle.
REQ-018 Rejected request: adr[1:0] != 0 or mem_read && mem_write -> next state DONE, with no byte strobes, err=1, and read_data unchanged.
REQ-019 mem_read only, aligned -> READ; mem_write only, aligned -> WRITE.
REQ-020 A 2-bit byte counter starts at 0 on entry to READ or WRITE; bmem_adr = latched adr + counter.
REQ-021 READ, each cycle: bmem_re=1; bmem_rdata is captured into lane 3-k (byte 0 -> bits 31:24) at the edge.
REQ-022 WRITE, each cycle: bmem_we=1; bmem_wdata = latched word lane 3-k.
REQ-023 After counter value 3, go to DONE; a legal access therefore spends exactly 4 cycles in READ or WRITE.
REQ-024 DONE lasts one cycle: mem_ready=1, busy=1, then return to IDLE.
REQ-025 Latency: mem_ready is high in the 5th cycle after the sampling edge for a legal access, and in the 1st cycle for a rejected request.
REQ-026 read_data updates only during READ captures and otherwise holds its value; it is stable from DONE until the next READ.
REQ-027 Requests arriving while not in IDLE are ignored; the latched adr and data do not change during an access.
REQ-028 A request still high in DONE is not re-sampled; it may be sampled in the following IDLE cycle.
REQ-029 Counter wrap from 3 to 0 never occurs inside one access.
REQ-030 Outside READ and WRITE: bmem_re = bmem_we = 0, bmem_adr = 0, bmem_wdata = 0.

Reset
REQ-031 rst asserted: state IDLE, counter 0, latched adr and data 0, read_data 0, and mem_ready, busy, err and all bmem outputs 0, immediately and independent of clk.
REQ-032 Reset mid-access aborts the access; no further bmem_we is issued and no mem_ready is issued for it.

Structure
REQ-033 The state encodings (2-bit) and the byte-count constant 4 are defined in a shared package, which is also used by the controller bench.
REQ-034 One natural sub-module: byte_lane_shifter, which selects and inserts byte lanes by counter value; everything else lives in mem_access_unit.

Verification
REQ-035 Read: byte memory 0x10..0x13 = AA,BB,CC,DD; mem_read, adr=0x10 -> bmem_re for 4 cycles at 0x10..0x13, mem_ready in cycle 5, read_data=0xAABBCCDD.
REQ-036 Write: mem_write, adr=0x20, write_data=0x12345678 -> bytes 12,34,56,78 at 0x20..0x23, mem_ready in cycle 5, err=0.
REQ-037 Misaligned: mem_read, adr=0x22 -> no strobes, mem_ready=err=1 in cycle 1, read_data unchanged.
REQ-038 Both mem_read and mem_write at adr=0x30 -> err pulse, no bmem_we.
REQ-039 rst asserted in the 3rd WRITE cycle -> all outputs 0 immediately, byte 0x23 untouched, no mem_ready.
REQ-040 Change adr from 0x10 to 0x40 during READ -> bmem_adr stays on 0x10..0x13 and the result is unaffected.
